// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: operand/CP0 constants,
// default HI/LO latencies, the stall-cause encoding and the operand comparator.
package hazard_ctrl_pkg;

   // Tuse value meaning "operand not read by this instruction"
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // CP0 register number of EPC
   localparam logic [4:0] EPC_ADDR = 5'd14;

   // Default HI/LO busy latencies and counter width
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int CNT_W_DEF    = 4;

   // Highest-priority reason for a stall in the current cycle
   typedef enum logic [2:0] {
      CAUSE_NONE = 3'd0,
      CAUSE_RS   = 3'd1,
      CAUSE_RT   = 3'd2,
      CAUSE_MD   = 3'd3,
      CAUSE_ERET = 3'd4
   } stall_cause_e;

   // Tuse/Tnew comparison of one ID operand against the EX and MEM producers.
   // $0 never carries a dependency and an unused operand never stalls.
   function automatic logic operand_hazard(
      input logic [4:0] id_addr,
      input logic [1:0] tuse,
      input logic [4:0] ex_waddr,
      input logic [1:0] ex_tnew,
      input logic [4:0] mem_waddr,
      input logic [1:0] mem_tnew
   );
      logic ex_hit;
      logic mem_hit;
      ex_hit  = (ex_waddr  == id_addr) && (ex_tnew  > tuse);
      mem_hit = (mem_waddr == id_addr) && (mem_tnew > tuse);
      return (id_addr != 5'd0) && (tuse != TUSE_NONE) && (ex_hit || mem_hit);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// HI/LO busy counter: loads the mult/div latency when an operation issues,
// counts down to zero, and reports busy including the issue cycle itself.
module md_busy_ctr
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_i,
   input  logic md_is_div_i,
   input  logic req_i,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             load_s;

   // A flushed EX instruction never reaches the HI/LO unit, so it must not load
   assign load_s = md_start_i && !req_i;

   // Next count: reload on issue (also while running), else saturating decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load_s) begin
         cnt_d = md_is_div_i ? DIV_LAT_C : MULT_LAT_C;
      end else if (cnt_q != CNT_ZERO) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = CNT_ZERO;
      end
   end

   // Count register, cleared immediately by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = load_s || (cnt_q != CNT_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: combines GRF data hazards, the HI/LO
// busy interlock and the ERET/EPC-write interlock into stall; flush follows req.
// Optional macro HAZARD_STATS_EN adds 32-bit stall_cnt and md_stall_cnt outputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [1:0]  id_tuse_rs,
   input  logic [1:0]  id_tuse_rt,
   input  logic        id_md,
   input  logic        id_eret,
   input  logic [4:0]  ex_waddr,
   input  logic [1:0]  ex_tnew,
   input  logic        ex_cp0we_epc,
   input  logic [4:0]  mem_waddr,
   input  logic [1:0]  mem_tnew,
   input  logic        mem_cp0we_epc,
   input  logic        md_start,
   input  logic        md_is_div,
   input  logic        req,
`ifdef HAZARD_STATS_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt,
`endif
   output logic        stall,
   output logic        flush,
   output logic        md_busy
);

   logic         haz_rs_s;
   logic         haz_rt_s;
   logic         haz_md_s;
   logic         haz_eret_s;
   logic         busy_s;
   stall_cause_e cause_s;

   md_busy_ctr #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_busy_ctr (
      .clk         (clk),
      .reset       (reset),
      .md_start_i  (md_start),
      .md_is_div_i (md_is_div),
      .req_i       (req),
      .busy_o      (busy_s)
   );

   assign haz_rs_s   = operand_hazard(id_rs, id_tuse_rs, ex_waddr, ex_tnew, mem_waddr, mem_tnew);
   assign haz_rt_s   = operand_hazard(id_rt, id_tuse_rt, ex_waddr, ex_tnew, mem_waddr, mem_tnew);
   assign haz_md_s   = id_md && busy_s;
   assign haz_eret_s = id_eret && (ex_cp0we_epc || mem_cp0we_epc);

   // Pick the dominant stall reason; an exception overrides every hazard
   always_comb begin
      cause_s = CAUSE_NONE;
      if (req) begin
         cause_s = CAUSE_NONE;
      end else if (haz_rs_s) begin
         cause_s = CAUSE_RS;
      end else if (haz_rt_s) begin
         cause_s = CAUSE_RT;
      end else if (haz_md_s) begin
         cause_s = CAUSE_MD;
      end else if (haz_eret_s) begin
         cause_s = CAUSE_ERET;
      end else begin
         cause_s = CAUSE_NONE;
      end
   end

   assign stall   = (cause_s != CAUSE_NONE);
   assign flush   = req;
   assign md_busy = busy_s;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] md_stall_cnt_q;
   logic [31:0] md_stall_cnt_d;

   // Counter next-state: every stall cycle, and stall cycles with HI/LO busy involved
   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      md_stall_cnt_d = md_stall_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
         if (haz_md_s) begin
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
         end else begin
            md_stall_cnt_d = md_stall_cnt_q;
         end
      end else begin
         stall_cnt_d    = stall_cnt_q;
         md_stall_cnt_d = md_stall_cnt_q;
      end
   end

   // Statistics registers, wrapping naturally at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q    <= 32'd0;
         md_stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         md_stall_cnt_q <= md_stall_cnt_d;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-numbered behavioural model.
module tb_hazard_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
   logic [1:0] id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
   logic       id_md, id_eret, ex_cp0we_epc, mem_cp0we_epc;
   logic       md_start, md_is_div, req;
   logic       stall, flush, md_busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_tuse_rs    (id_tuse_rs),
      .id_tuse_rt    (id_tuse_rt),
      .id_md         (id_md),
      .id_eret       (id_eret),
      .ex_waddr      (ex_waddr),
      .ex_tnew       (ex_tnew),
      .ex_cp0we_epc  (ex_cp0we_epc),
      .mem_waddr     (mem_waddr),
      .mem_tnew      (mem_tnew),
      .mem_cp0we_epc (mem_cp0we_epc),
      .md_start      (md_start),
      .md_is_div     (md_is_div),
      .req           (req),
`ifdef HAZARD_STATS_EN
      .stall_cnt     (stall_cnt),
      .md_stall_cnt  (md_stall_cnt),
`endif
      .stall         (stall),
      .flush         (flush),
      .md_busy       (md_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: cycle number and the last cycle in which HI/LO is still busy
   int cyc        = 0;
   int busy_until = -1;
   int m_stalls   = 0;
   int m_mdstalls = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit m_op_haz(input logic [4:0] a, input logic [1:0] tuse);
      if (a == 5'd0 || tuse == 2'd3) return 1'b0;
      return (ex_waddr == a && int'(ex_tnew) > int'(tuse)) ||
             (mem_waddr == a && int'(mem_tnew) > int'(tuse));
   endfunction

   function automatic bit m_busy();
      return (md_start && !req) || (cyc <= busy_until);
   endfunction

   function automatic bit m_md_haz();
      return id_md && m_busy();
   endfunction

   function automatic bit m_stall();
      if (req) return 1'b0;
      return m_op_haz(id_rs, id_tuse_rs) || m_op_haz(id_rt, id_tuse_rt) || m_md_haz() ||
             (id_eret && (ex_cp0we_epc || mem_cp0we_epc));
   endfunction

   task automatic m_reset();
      busy_until = -1;
      m_stalls   = 0;
      m_mdstalls = 0;
   endtask

   // Check outputs mid-cycle, then advance the model across the next rising edge
   task automatic tick();
      bit s, md;
      @(negedge clk);
      s  = m_stall();
      md = m_md_haz();
      check_eq("stall",   32'(stall),   32'(s));
      check_eq("flush",   32'(flush),   32'(req));
      check_eq("md_busy", 32'(md_busy), 32'(m_busy()));
`ifdef HAZARD_STATS_EN
      check_eq("stall_cnt",    stall_cnt,    32'(m_stalls));
      check_eq("md_stall_cnt", md_stall_cnt, 32'(m_mdstalls));
`endif
      @(posedge clk);
      if (md_start && !req) busy_until = cyc + (md_is_div ? DIV_LAT : MULT_LAT);
      if (s) m_stalls++;
      if (s && md) m_mdstalls++;
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
      id_md = 1'b0; id_eret = 1'b0;
      ex_waddr = 5'd0; ex_tnew = 2'd0; ex_cp0we_epc = 1'b0;
      mem_waddr = 5'd0; mem_tnew = 2'd0; mem_cp0we_epc = 1'b0;
      md_start = 1'b0; md_is_div = 1'b0; req = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      m_reset();
      #2;
      check_eq("rst_stall",   32'(stall),   32'd0);
      check_eq("rst_flush",   32'(flush),   32'd0);
      check_eq("rst_md_busy", 32'(md_busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // lw-use: producer in EX not ready, then same producer one stage later
      ex_waddr = 5'd5; ex_tnew = 2'd2; id_rs = 5'd5; id_tuse_rs = 2'd1;
      #1 check_eq("lwuse_stall", 32'(stall), 32'd1);
      tick();
      ex_waddr = 5'd0; ex_tnew = 2'd0; mem_waddr = 5'd5; mem_tnew = 2'd1;
      #1 check_eq("lwuse_mem_clear", 32'(stall), 32'd0);
      tick();

      // $0 never stalls; an unused rt never stalls
      idle_inputs();
      ex_waddr = 5'd0; ex_tnew = 2'd2; id_rs = 5'd0; id_tuse_rs = 2'd0;
      #1 check_eq("zero_reg", 32'(stall), 32'd0);
      tick();
      idle_inputs();
      ex_waddr = 5'd9; ex_tnew = 2'd2; id_rt = 5'd9; id_tuse_rt = 2'd3;
      #1 check_eq("rt_unused", 32'(stall), 32'd0);
      tick();

      // mult then mfhi, then div then mfhi
      for (int k = 0; k < 2; k++) begin
         int lat;
         lat = (k == 0) ? MULT_LAT : DIV_LAT;
         idle_inputs();
         reset = 1'b1; m_reset(); #1 reset = 1'b0;
         id_md = 1'b1; md_start = 1'b1; md_is_div = (k == 1);
         for (int c = 0; c <= lat + 1; c++) begin
            #1 check_eq(k == 0 ? "mult_stall" : "div_stall", 32'(stall), 32'(c <= lat));
            tick();
            md_start = 1'b0;
         end
`ifdef HAZARD_STATS_EN
         if (k == 0) check_eq("mult_stall_cnt", stall_cnt, 32'd6);
`endif
      end

      // req beats a data hazard and blocks the counter load
      idle_inputs();
      ex_waddr = 5'd3; ex_tnew = 2'd2; id_rs = 5'd3; id_tuse_rs = 2'd0;
      md_start = 1'b1; req = 1'b1;
      #1 check_eq("req_stall", 32'(stall), 32'd0);
      check_eq("req_flush", 32'(flush), 32'd1);
      tick();
      idle_inputs();
      #1 check_eq("req_no_load", 32'(md_busy), 32'd0);
      tick();

      // eret waits for an EPC writer in MEM
      id_eret = 1'b1; mem_cp0we_epc = 1'b1;
      #1 check_eq("eret_stall", 32'(stall), 32'd1);
      tick();
      mem_cp0we_epc = 1'b0;
      #1 check_eq("eret_clear", 32'(stall), 32'd0);
      tick();

      // asynchronous reset with the counter at 7
      idle_inputs();
      md_start = 1'b1; md_is_div = 1'b1;
      tick();
      md_start = 1'b0;
      repeat (3) tick();
      check_eq("busy_at_7", 32'(md_busy), 32'd1);
      reset = 1'b1;
      m_reset();
      #1 check_eq("async_rst_busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_STATS_EN
      check_eq("async_rst_stall_cnt", stall_cnt, 32'd0);
`endif
      #1 reset = 1'b0;
      tick();

      // randomized traffic with small address space to provoke matches
      for (int n = 0; n < 600; n++) begin
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         id_tuse_rs    = 2'($urandom_range(0, 3));
         id_tuse_rt    = 2'($urandom_range(0, 3));
         id_md         = ($urandom_range(0, 2) == 0);
         id_eret       = ($urandom_range(0, 3) == 0);
         ex_waddr      = 5'($urandom_range(0, 3));
         ex_tnew       = 2'($urandom_range(0, 2));
         ex_cp0we_epc  = ($urandom_range(0, 5) == 0);
         mem_waddr     = 5'($urandom_range(0, 3));
         mem_tnew      = 2'($urandom_range(0, 1));
         mem_cp0we_epc = ($urandom_range(0, 5) == 0);
         md_start      = ($urandom_range(0, 7) == 0);
         md_is_div     = $urandom_range(0, 1) == 1;
         req           = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
